prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 134 +++++++++++++
 tb/tb_prog_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses an instruction block and a data block,
// each preceded by a little-endian word count, and issues memory write strobes.
module prog_loader #(
  parameter logic [31:0] IMEM_BASE = 32'h0,
  parameter logic [31:0] DMEM_BASE = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic [31:0]  addr,
  output logic [127:0] data,
  output logic         we_128,
  output logic         we_32,
  output logic         done
);

  typedef enum logic [2:0] {HDR_I, LOAD_I, HDR_D, LOAD_D, DONE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    words_q, words_d;
  logic [127:0]   data_q, data_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           we128_q, we128_d;
  logic           we32_q, we32_d;
  logic           done_q, done_d;

  logic           accept;
  logic           cnt_last;
  logic [31:0]    hdr_val;

  always_comb begin
    accept   = rx_valid && (state_q != DONE);
    cnt_last = (cnt_q == ((state_q == LOAD_I) ? 4'd15 : 4'd3));
    // Header value as it will look once the current (4th) byte is shifted in.
    hdr_val  = {rx_data, data_q[127:104]};

    state_d  = state_q;
    addr_d   = addr_q;
    words_d  = words_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    we128_d  = 1'b0;
    we32_d   = 1'b0;
    done_d   = done_q;

    if (accept) begin
      data_d = {rx_data, data_q[127:8]};
      cnt_d  = cnt_last ? 4'd0 : cnt_q + 4'd1;
    end

    case (state_q)
      HDR_I: begin
        if (accept && cnt_last) begin
          if (hdr_val == 32'd0) begin
            state_d = HDR_D;
          end else begin
            words_d = hdr_val;
            state_d = LOAD_I;
          end
        end
      end
      LOAD_I: begin
        if (accept && cnt_last) we128_d = 1'b1;
        // A byte accepted during the write cycle already counts toward the next word/header.
        if (we128_q) begin
          addr_d  = addr_q + 32'd16;
          words_d = words_q - 32'd1;
          if (words_q == 32'd1) begin
            state_d = HDR_D;
            cnt_d   = accept ? 4'd1 : 4'd0;
          end
        end
      end
      HDR_D: begin
        if (accept && cnt_last) begin
          if (hdr_val == 32'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            words_d = hdr_val;
            addr_d  = DMEM_BASE;
            state_d = LOAD_D;
          end
        end
      end
      LOAD_D: begin
        if (accept && cnt_last) we32_d = 1'b1;
        if (we32_q) begin
          addr_d  = addr_q + 32'd4;
          words_d = words_q - 32'd1;
          if (words_q == 32'd1) begin
            state_d = DONE;
            done_d  = 1'b1;
            cnt_d   = 4'd0;
          end
        end
      end
      DONE: begin
      end
      default: state_d = HDR_I;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HDR_I;
      addr_q  <= IMEM_BASE;
      words_q <= 32'd0;
      data_q  <= 128'd0;
      cnt_q   <= 4'd0;
      we128_q <= 1'b0;
      we32_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      we128_q <= we128_d;
      we32_q  <= we32_d;
      done_q  <= done_d;
    end
  end

  assign addr   = addr_q;
  assign data   = data_q;
  assign we_128 = we128_q;
  assign we_32  = we32_q;
  assign done   = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-cycle vector table plus stream sequences
// checked against write events captured from two instances (default and high IMEM base).
module tb_prog_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_valid;
  logic [7:0]   rx_data;

  logic [31:0]  a_addr, b_addr;
  logic [127:0] a_data, b_data;
  logic         a_we_128, a_we_32, a_done;
  logic         b_we_128, b_we_32, b_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prog_loader dut_a (
    .clk(clk), .reset(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .addr(a_addr), .data(a_data), .we_128(a_we_128), .we_32(a_we_32), .done(a_done)
  );

  prog_loader #(.IMEM_BASE(32'hFFFF_FFF0), .DMEM_BASE(32'h0000_1000)) dut_b (
    .clk(clk), .reset(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .addr(b_addr), .data(b_data), .we_128(b_we_128), .we_32(b_we_32), .done(b_done)
  );

  typedef struct {
    logic         is128;
    logic [31:0]  addr;
    logic [127:0] data;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        w128;
    logic        w32;
    logic [31:0] ad;
    logic        dn;
    logic        ct;
    logic [31:0] top;
  } vec_t;

  vec_t tbl[17];

  // Capture every write strobe; both strobes together is an immediate failure.
  always @(negedge clk) begin
    if (a_we_128 || a_we_32) begin
      qa.push_back('{a_we_128, a_addr, a_data});
      total++;
      if (a_we_128 && a_we_32) begin
        bad++;
        $display("FAIL dual_strobe_a: got we_128=1 we_32=1, required at most one");
      end
    end
    if (b_we_128 || b_we_32) begin
      qb.push_back('{b_we_128, b_addr, b_data});
      total++;
      if (b_we_128 && b_we_32) begin
        bad++;
        $display("FAIL dual_strobe_b: got we_128=1 we_32=1, required at most one");
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input bit on_b, input string name, input bit is128,
                           input logic [31:0] ad, input logic [127:0] d);
    ev_t e;
    int  n;
    n = on_b ? qb.size() : qa.size();
    total++;
    if (n == 0) begin
      bad++;
      $display("FAIL %s: got no write strobe, required one", name);
    end else begin
      e = on_b ? qb.pop_front() : qa.pop_front();
      chk({name, "_kind"}, 128'(e.is128), 128'(is128));
      chk({name, "_addr"}, 128'(e.addr), 128'(ad));
      if (is128) chk({name, "_data"}, e.data, d);
      else       chk({name, "_data"}, 128'(e.data[127:96]), 128'(d[31:0]));
    end
  endtask

  // Inputs change #1 after a rising edge; outputs are read #1 after the next one.
  task automatic put(input bit v, input logic [7:0] b);
    rx_valid = v;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic put32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) put(1'b1, w[8*i +: 8]);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  function automatic logic [127:0] word_of(input logic [7:0] base);
    logic [127:0] m;
    for (int k = 0; k < 16; k++) m[8*k +: 8] = base + 8'(k);
    return m;
  endfunction

  initial begin
    logic [31:0]  sv_addr;
    logic [127:0] sv_data;

    tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 8'h02, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 8'h11, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 8'h22, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 8'h33, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 8'h44, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h4433_2211};
    tbl[12] = '{1'b1, 8'h55, 1'b0, 1'b0, 32'h4, 1'b0, 1'b1, 32'h5544_3322};
    tbl[13] = '{1'b1, 8'h66, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 32'h0};
    tbl[14] = '{1'b1, 8'h77, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 8'h88, 1'b0, 1'b1, 32'h4, 1'b0, 1'b1, 32'h8877_6655};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h8, 1'b1, 1'b1, 32'h8877_6655};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #2;
    chk("rst_addr_a", 128'(a_addr), 128'h0);
    chk("rst_addr_b", 128'(b_addr), 128'hFFFF_FFF0);
    chk("rst_data",   a_data, 128'h0);
    chk("rst_strobe", {126'h0, a_we_128, a_we_32}, 128'h0);
    chk("rst_done",   128'(a_done), 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // WI=1 back-to-back, then WD=0 whose first byte lands in the write cycle.
    put32(32'd1);
    for (int k = 0; k < 16; k++) put(1'b1, 8'(k));
    chk("s1_done_early", 128'(a_done), 128'h0);
    put32(32'd0);
    chk("s1_done", 128'(a_done), 128'h1);
    expect_ev(1'b0, "s1_w0", 1'b1, 32'h0, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("s1_extra", 128'(qa.size()), 128'h0);

    // Bytes after done are ignored.
    sv_addr = a_addr;
    sv_data = a_data;
    for (int i = 0; i < 5; i++) put(1'b1, 8'h5A + 8'(i));
    chk("s5_strobes", 128'(qa.size()), 128'h0);
    chk("s5_addr", 128'(a_addr), 128'(sv_addr));
    chk("s5_data", a_data, sv_data);
    chk("s5_done", 128'(a_done), 128'h1);

    // WI=0, WD=2, checked cycle by cycle from the table.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      put(tbl[i].v, tbl[i].b);
      chk($sformatf("v%0d_we128", i), 128'(a_we_128), 128'(tbl[i].w128));
      chk($sformatf("v%0d_we32", i),  128'(a_we_32),  128'(tbl[i].w32));
      chk($sformatf("v%0d_addr", i),  128'(a_addr),   128'(tbl[i].ad));
      chk($sformatf("v%0d_done", i),  128'(a_done),   128'(tbl[i].dn));
      if (tbl[i].ct) chk($sformatf("v%0d_top", i), 128'(a_data[127:96]), 128'(tbl[i].top));
    end

    // WI=3 with random idle gaps between every byte.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) put(1'b0, 8'h00);
      put(1'b1, (i == 0) ? 8'h03 : 8'h00);
    end
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 16; k++) begin
        repeat ($urandom_range(0, 3)) put(1'b0, 8'h00);
        put(1'b1, 8'h30 + 8'(16 * w + k));
      end
    end
    put(1'b0, 8'h00);
    put(1'b0, 8'h00);
    for (int w = 0; w < 3; w++)
      expect_ev(1'b0, $sformatf("s3_w%0d", w), 1'b1, 32'(16 * w), word_of(8'h30 + 8'(16 * w)));
    chk("s3_extra", 128'(qa.size()), 128'h0);
    chk("s3_done", 128'(a_done), 128'h0);

    // Reset in the middle of an instruction word, then a complete reload.
    do_reset();
    put32(32'd1);
    for (int k = 0; k < 9; k++) put(1'b1, 8'hA0 + 8'(k));
    #2;
    rst = 1'b1;
    #1;
    chk("s4_rst_addr", 128'(a_addr), 128'h0);
    chk("s4_rst_data", a_data, 128'h0);
    chk("s4_rst_strobe", {126'h0, a_we_128, a_we_32}, 128'h0);
    chk("s4_rst_done", 128'(a_done), 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete();
    qb.delete();
    put32(32'd1);
    for (int k = 0; k < 16; k++) put(1'b1, 8'hC0 + 8'(k));
    put32(32'd1);
    put(1'b1, 8'hD1);
    put(1'b1, 8'hD2);
    put(1'b1, 8'hD3);
    put(1'b1, 8'hD4);
    put(1'b0, 8'h00);
    expect_ev(1'b0, "s4_i", 1'b1, 32'h0, word_of(8'hC0));
    expect_ev(1'b0, "s4_d", 1'b0, 32'h0, 128'(32'hD4D3_D2D1));
    chk("s4_done", 128'(a_done), 128'h1);

    // High IMEM base: second write wraps to address 0.
    do_reset();
    put32(32'd2);
    for (int k = 0; k < 32; k++) put(1'b1, 8'h70 + 8'(k));
    put32(32'd0);
    put(1'b0, 8'h00);
    expect_ev(1'b1, "s6_w0", 1'b1, 32'hFFFF_FFF0, word_of(8'h70));
    expect_ev(1'b1, "s6_w1", 1'b1, 32'h0000_0000, word_of(8'h80));
    chk("s6_extra", 128'(qb.size()), 128'h0);
    chk("s6_done", 128'(b_done), 128'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
